seq_divider: RTL and testbench

//   Multi-cycle restoring integer divider for the ToyALU datapath. It is the inverse of the
//   32-bit carry-lookahead adder: it divides by repeated trial subtraction, one quotient bit
//   per cycle. Operands are accepted and results returned over valid/ready handshakes, so the
//   ALU can stall on DIV/REM without a combinational divide path.

---
 rtl/seq_divider.sv | 189 ++++++++++++++++++
 tb/tb_seq_divider.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle restoring integer divider. It produces one quotient
//               bit per cycle by trial subtraction. Operands and results move
//               over valid/ready handshakes, so there is no combinational
//               divide path.
//   clk          in   1      clock, rising-edge active
//   rst          in   1      synchronous active-high reset (aborts op in flight)
//   in_valid     in   1      dividend/divisor valid
//   in_ready     out  1      operands accepted (high only in IDLE)
//   dividend     in   WIDTH  numerator
//   divisor      in   WIDTH  denominator
//   out_valid    out  1      result valid (high only in DONE)
//   out_ready    in   1      consumer accepts result
//   quotient     out  WIDTH  result quotient
//   remainder    out  WIDTH  result remainder
//   div_by_zero  out  1      divisor was zero for this result
// Build option: define SIGNED_DIV_EN for two's-complement operands.
// Revision    : 1.0  initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_q;        // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]   r_rem;      // running partial remainder
    logic [WIDTH-1:0]   r_dvsr;     // latched divisor (magnitude)
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_remd;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_partial;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_q_step;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quot_fin;
    logic [WIDTH-1:0]   w_rem_fin;
    logic [WIDTH-1:0]   w_dvnd_mag;
    logic [WIDTH-1:0]   w_dvsr_mag;
    logic               w_last;
    logic               w_div_zero;

    // One restoring step: shift the next dividend bit into the remainder and
    // keep the subtraction only when it does not borrow.
    assign w_partial  = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_diff     = {1'b0, w_partial} - {1'b0, r_dvsr};
    assign w_rem_step = w_diff[WIDTH] ? w_partial : w_diff[WIDTH-1:0];
    assign w_q_step   = {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_div_zero = (divisor == '0);

`ifdef SIGNED_DIV_EN
    logic r_neg_q;
    logic r_neg_r;

    // Divide magnitudes; MIN maps onto itself, which is the correct unsigned
    // magnitude 2^(WIDTH-1), so MIN / -1 naturally yields quotient MIN.
    assign w_dvnd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_dvsr_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign w_quot_fin = r_neg_q ? -w_q_step   : w_q_step;
    assign w_rem_fin  = r_neg_r ? -w_rem_step : w_rem_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign w_dvnd_mag = dividend;
    assign w_dvsr_mag = divisor;
    assign w_quot_fin = w_q_step;
    assign w_rem_fin  = w_rem_step;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = w_div_zero ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath. Result registers are only written on entry to DONE, so they
    // stay stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_dvsr <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_remd <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_q    <= w_dvnd_mag;
                        r_rem  <= '0;
                        r_dvsr <= w_dvsr_mag;
                        r_cnt  <= '0;
                        if (w_div_zero) begin
                            r_quot <= '1;
                            r_remd <= dividend;
                            r_dbz  <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_q   <= w_q_step;
                    r_rem <= w_rem_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_quot <= w_quot_fin;
                        r_remd <= w_rem_fin;
                        r_dbz  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_remd;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider (WIDTH=32). Table-driven
//               vectors plus hand-written stall, reset-abort and random runs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    wire          in_ready;
    wire          out_valid;
    wire  [W-1:0] quotient;
    wire  [W-1:0] remainder;
    wire          div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Present operands, wait (bounded) for acceptance, then scramble inputs
    // so that the DUT must rely on its latched copies.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Cycles from the handshake cycle to the first cycle with out_valid.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int           lat;
        logic [W-1:0] hq;
        logic [W-1:0] hr;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

`ifdef SIGNED_DIV_EN
        vecs.push_back({32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});
        vecs.push_back({32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0});
        vecs.push_back({32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0});
        vecs.push_back({32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0});
        vecs.push_back({32'd100,      32'd7,        32'd14,       32'd2,        1'b0});
        vecs.push_back({32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1});
        vecs.push_back({32'd0,        32'd5,        32'd0,        32'd0,        1'b0});
`else
        vecs.push_back({32'd100,      32'd7,        32'd14,       32'd2,        1'b0});
        vecs.push_back({32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1});
        vecs.push_back({32'd5,        32'd9,        32'd0,        32'd5,        1'b0});
        vecs.push_back({32'd0,        32'd5,        32'd0,        32'd0,        1'b0});
        vecs.push_back({32'd1000,     32'd3,        32'd333,      32'd1,        1'b0});
        vecs.push_back({32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0});
        vecs.push_back({32'h80000000, 32'd2,        32'h40000000, 32'd0,        1'b0});
        vecs.push_back({32'd7,        32'h80000000, 32'd0,        32'd7,        1'b0});
        vecs.push_back({32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE, 1'b0});
        vecs.push_back({32'hDEADBEEF, 32'h10,       32'h0DEADBEE, 32'hF,        1'b0});
        vecs.push_back({32'd0,        32'd0,        32'hFFFFFFFF, 32'd0,        1'b1});
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  {63'd0, in_ready},    64'd1);
        check("reset_out_valid", {63'd0, out_valid},   64'd0);
        check("reset_quotient",  {32'd0, quotient},    64'd0);
        check("reset_remainder", {32'd0, remainder},   64'd0);
        check("reset_dbz",       {63'd0, div_by_zero}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table: out_ready held high, result must be taken in its first DONE cycle.
        foreach (vecs[i]) begin
            out_ready = 1'b1;
            start_op(vecs[i].a, vecs[i].b);
            wait_result(lat);
            check($sformatf("v%0d_latency", i), 64'(lat), vecs[i].z ? 64'd1 : 64'(W + 1));
            check($sformatf("v%0d_quotient", i),  {32'd0, quotient},    {32'd0, vecs[i].q});
            check($sformatf("v%0d_remainder", i), {32'd0, remainder},   {32'd0, vecs[i].r});
            check($sformatf("v%0d_dbz", i),       {63'd0, div_by_zero}, {63'd0, vecs[i].z});
            check($sformatf("v%0d_in_ready_done", i), {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_consumed", i), {62'd0, out_valid, in_ready}, 64'd1);
            out_ready = 1'b0;
        end

        // Consumer stall: outputs hold, in_ready low until after the handshake.
        out_ready = 1'b0;
        start_op(32'hFFFFFFFF, 32'd1);
        wait_result(lat);
        check("hold_latency", 64'(lat), 64'(W + 1));
        hq = quotient;
        hr = remainder;
`ifdef SIGNED_DIV_EN
        check("hold_quotient", {32'd0, hq}, 64'hFFFFFFFF);
`else
        check("hold_quotient", {32'd0, hq}, 64'hFFFFFFFF);
`endif
        check("hold_remainder", {32'd0, hr}, 64'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_flags", k), {61'd0, out_valid, in_ready, div_by_zero}, 64'h4);
            check($sformatf("hold%0d_q", k), {32'd0, quotient},  64'hFFFFFFFF);
            check($sformatf("hold%0d_r", k), {32'd0, remainder}, 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("hold_hs_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_after_hs", {62'd0, out_valid, in_ready}, 64'd1);

        // Reset mid-operation aborts it.
        start_op(32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_flags", {62'd0, out_valid, in_ready}, 64'd1);
        check("abort_quotient",  {32'd0, quotient},    64'd0);
        check("abort_remainder", {32'd0, remainder},   64'd0);
        check("abort_dbz",       {63'd0, div_by_zero}, 64'd0);
        repeat (W + 4) @(posedge clk);
        #1;
        check("abort_no_result", {62'd0, out_valid, in_ready}, 64'd1);
        start_op(32'd9, 32'd3);
        wait_result(lat);
        check("after_abort_latency",   64'(lat), 64'(W + 1));
        check("after_abort_quotient",  {32'd0, quotient},  64'd3);
        check("after_abort_remainder", {32'd0, remainder}, 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

`ifndef SIGNED_DIV_EN
        // Random unsigned pairs against the language's own divide.
        for (int k = 0; k < 200; k++) begin
            ra = $urandom;
            rb = (k % 4 == 0) ? W'($urandom_range(1, 300)) : W'($urandom >> $urandom_range(0, 31));
            out_ready = 1'b1;
            start_op(ra, rb);
            wait_result(lat);
            if (rb == 0) begin
                check($sformatf("rnd%0d_qr", k), {quotient, remainder}, {32'hFFFFFFFF, ra});
            end else begin
                check($sformatf("rnd%0d_qr", k), {quotient, remainder}, {ra / rb, ra % rb});
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
